// File: rtl/elixirchip_es1_spu_op_reg_bank.sv
// Bank of independently held channel values with per-channel write/clear,
// a global clear, and a cke-gated output pipeline that keeps update flags aligned with data.
module elixirchip_es1_spu_op_reg_bank #(
  parameter int                   CHANNELS   = 4,
  parameter int                   DATA_BITS  = 8,
  parameter int                   LATENCY    = 1,
  parameter logic [DATA_BITS-1:0] CLEAR_DATA = '0,
  parameter int                   SEL_BITS   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  parameter                       DEVICE     = "RTL",
  parameter                       SIMULATION = "false",
  parameter                       DEBUG      = "false"
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          cke,
  input  logic [SEL_BITS-1:0]           s_sel,
  input  logic [DATA_BITS-1:0]          s_data,
  input  logic                          s_valid,
  input  logic                          s_clear,
  input  logic                          s_clear_all,
  output logic [CHANNELS*DATA_BITS-1:0] m_data,
  output logic [CHANNELS-1:0]           m_updated,
  output logic                          m_sel_err
);

  // One extra bit so CHANNELS itself is representable when it is a power of two.
  localparam logic [SEL_BITS:0] CH_LIMIT = (SEL_BITS+1)'(CHANNELS);

  logic [DATA_BITS-1:0] r_data [LATENCY][CHANNELS];
  logic [CHANNELS-1:0]  r_upd  [LATENCY];
  logic                 r_sel_err;

  logic [DATA_BITS-1:0] w_next_data [CHANNELS];
  logic [CHANNELS-1:0]  w_next_upd;
  logic                 w_sel_ok;
  logic                 w_sel_err;
  logic                 w_unused;

  assign w_sel_ok  = ({1'b0, s_sel} < CH_LIMIT);
  assign w_sel_err = (s_valid | s_clear) & ~w_sel_ok;

  // Pass-through parameters carry no function.
  assign w_unused = ^{DEVICE, SIMULATION, DEBUG};

  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      w_next_data[k] = r_data[0][k];
      w_next_upd[k]  = 1'b0;
      if (s_clear_all) begin
        w_next_data[k] = CLEAR_DATA;
        w_next_upd[k]  = 1'b1;
      end else if (w_sel_ok && (s_sel == SEL_BITS'(k))) begin
        if (s_clear) begin
          w_next_data[k] = CLEAR_DATA;
          w_next_upd[k]  = 1'b1;
        end else if (s_valid) begin
          w_next_data[k] = s_data;
          w_next_upd[k]  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int s = 0; s < LATENCY; s++) begin
        for (int k = 0; k < CHANNELS; k++) begin
          r_data[s][k] <= CLEAR_DATA;
        end
        r_upd[s] <= '0;
      end
      r_sel_err <= 1'b0;
    end else if (cke) begin
      r_data[0] <= w_next_data;
      r_upd[0]  <= w_next_upd;
      for (int s = 1; s < LATENCY; s++) begin
        r_data[s] <= r_data[s-1];
        r_upd[s]  <= r_upd[s-1];
      end
      if (w_sel_err) begin
        r_sel_err <= 1'b1;
      end
    end
  end

  generate
    for (genvar k = 0; k < CHANNELS; k++) begin : g_out
      assign m_data[k*DATA_BITS +: DATA_BITS] = r_data[LATENCY-1][k];
    end
  endgenerate

  assign m_updated = r_upd[LATENCY-1];
  assign m_sel_err = r_sel_err;

endmodule

// File: doc/elixirchip_es1_spu_op_reg_bank.md
ELIXIRCHIP_ES1_SPU_OP_REG_BANK -- requirements
Module: elixirchip_es1_spu_op_reg_bank

Interface
REQ-001 SHALL provide parameter CHANNELS, default 4: number of independent held-value channels, range 1..16.
REQ-002 SHALL provide parameter DATA_BITS, default 8: per-channel data width, range 1..64.
REQ-003 SHALL provide parameter LATENCY, default 1: cke-enabled clock edges from input sample to visible m_data, range 1..4.
REQ-004 SHALL provide parameter CLEAR_DATA, default 0: DATA_BITS-wide reset/clear value for every channel.
REQ-005 SHALL provide parameter SEL_BITS, default max(1, clog2(CHANNELS)): s_sel width.
REQ-006 SHALL provide parameters DEVICE "RTL", SIMULATION "false", DEBUG "false": passed through, no functional effect.
REQ-007 SHALL provide port clk  input  1  sole clock, all logic on rising edge.
REQ-008 SHALL provide port reset_n  input  1  reset, synchronous and active-low.
REQ-009 SHALL provide port cke  input  1  clock enable; all state, pipeline and flags hold when 0.
REQ-010 SHALL provide port s_sel  input  SEL_BITS  target channel for s_data/s_clear.
REQ-011 SHALL provide port s_data  input  DATA_BITS  write data.
REQ-012 SHALL provide port s_valid  input  1  write s_data into channel s_sel.
REQ-013 SHALL provide port s_clear  input  1  load CLEAR_DATA into channel s_sel.
REQ-014 SHALL provide port s_clear_all  input  1  load CLEAR_DATA into all channels.
REQ-015 SHALL provide port m_data  output  CHANNELS*DATA_BITS  channel k held value at bits [k*DATA_BITS +: DATA_BITS].
REQ-016 SHALL provide port m_updated  output  CHANNELS  per-channel one-cycle flag, 1 when that channel's value changed source this sample (write or clear), aligned with m_data.
REQ-017 SHALL provide port m_sel_err  output  1  sticky flag, out-of-range s_sel used with s_valid or s_clear.

Function
REQ-018 SHALL, on a cke=1 edge, update held-value stage 0 per channel with priority s_clear_all > s_clear (selected) > s_valid (selected) > hold.
REQ-019 SHALL leave all channels other than s_sel unchanged unless s_clear_all=1.
REQ-020 SHALL delay stage 0 through LATENCY-1 further cke-gated register stages so m_data reflects an input LATENCY cke edges after it was sampled; LATENCY=1 means m_data is stage 0 directly.
REQ-021 SHALL carry m_updated through the same stage count as m_data, so flag and data always align.
REQ-022 SHALL, when cke=0, hold stage 0, every pipeline stage, m_updated and m_sel_err; inputs on that edge are discarded.
REQ-023 SHALL treat s_sel >= CHANNELS as no-op for s_valid/s_clear (no channel changes, m_updated bit 0) and set m_sel_err to 1 on that cke edge.
REQ-024 SHALL still honour s_clear_all when s_sel is out of range, without setting m_sel_err unless s_valid or s_clear is also 1.
REQ-025 SHALL hold m_sel_err at 1 until reset; no other clear mechanism.
REQ-026 SHALL ignore s_data when s_valid=0 or a clear wins; s_data treated as raw bits, no sign/width conversion.
REQ-027 SHALL set m_updated[k]=1 for every channel on s_clear_all even if value already equals CLEAR_DATA.

Reset
REQ-028 SHALL, on a clk edge with reset_n=0, regardless of cke, load CLEAR_DATA into stage 0 and every pipeline stage of every channel.
REQ-029 SHALL, under reset, drive m_updated to 0 and m_sel_err to 0 from the next edge onward.
REQ-030 SHALL discard in-flight pipeline contents on reset mid-operation; first valid sample after reset_n rises appears LATENCY cke edges later.

Verification (CHANNELS=4, DATA_BITS=8, LATENCY=3, CLEAR_DATA=123)
REQ-031 SHALL cover reset: hold reset_n=0 3 cycles -> all m_data lanes 123, m_updated=0000, m_sel_err=0.
REQ-032 SHALL cover write/latency: s_sel=2,s_data=5,s_valid=1 one cycle -> lane2=5 and m_updated=0100 exactly 3 edges later, one cycle; lanes 0,1,3 stay 123.
REQ-033 SHALL cover priority: same cycle s_sel=1,s_data=9,s_valid=1,s_clear=1 -> lane1=123; then s_clear_all=1,s_valid=1 -> all lanes 123, m_updated=1111.
REQ-034 SHALL cover cke stall: write lane0=7 then cke=0 for 2 cycles mid-pipeline -> lane0=7 appears after 3 cke=1 edges (5 clocks), inputs during cke=0 ignored.
REQ-035 SHALL cover out-of-range: CHANNELS=3, s_sel=3,s_valid=1,s_data=44 -> no lane changes, m_sel_err=1 and stays 1 until reset_n=0.
REQ-036 SHALL cover reset mid-flight: write lane3=88, assert reset_n=0 one edge later -> lane3 never shows 88, reads 123.
